uart_configurable: RTL



---
 rtl/uart_configurable.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_configurable.sv
// Configurable UART with FWFT TX/RX FIFOs, majority-vote RX sampling,
// false-start rejection and sticky receive error flags.
module uart_configurable #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 uart_tx_pin,
    input  logic                 uart_rx_pin,
    input  logic [DATA_BITS-1:0] tx_fifo_data_in,
    input  logic                 tx_fifo_write_en,
    output logic                 tx_fifo_full,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_fifo_data_out,
    input  logic                 rx_fifo_read_en,
    output logic                 rx_fifo_empty,
    output logic                 rx_frame_error,
    output logic                 rx_parity_error,
    output logic                 rx_overrun,
    input  logic                 error_clear
);

    localparam int BIT_TICKS = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF      = BIT_TICKS / 2;
    localparam int CW        = $clog2(STOP_BITS * BIT_TICKS + 1);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * BIT_TICKS - 1);
    localparam logic [CW-1:0] SMP0     = CW'(HALF - 1);
    localparam logic [CW-1:0] SMP1     = CW'(HALF);
    localparam logic [CW-1:0] SMP2     = CW'(HALF + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic           tx_push, tx_pop, tx_load, tx_fifo_empty, rx_push, rx_pop, rx_fifo_full;
    logic [DATA_BITS-1:0] tx_head;

    tx_state_t      tx_state_q, tx_state_d;
    logic [CW-1:0]  tx_tick_q, tx_tick_d;
    logic [2:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic           tx_par_q, tx_par_d, tx_pin_q, tx_pin_d;

    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t      rx_state_q, rx_state_d;
    logic [CW-1:0]  rx_tick_q, rx_tick_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [1:0]     rx_votes_q, rx_votes_d, rx_sum;
    logic           rx_vote;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic           rx_push_q, rx_push_d;
    logic           frame_set, parity_set, overrun_set;
    logic           rx_frame_err_q, rx_frame_err_d, rx_parity_err_q, rx_parity_err_d;
    logic           rx_overrun_q, rx_overrun_d;

    assign tx_fifo_empty    = (tx_cnt_q == '0);
    assign tx_fifo_full     = (tx_cnt_q == FULL_CNT);
    assign tx_head          = tx_mem_q[tx_rd_q];
    assign rx_fifo_empty    = (rx_cnt_q == '0);
    assign rx_fifo_full     = (rx_cnt_q == FULL_CNT);
    assign rx_fifo_data_out = rx_mem_q[rx_rd_q];
    assign uart_tx_pin      = tx_pin_q;
    assign tx_busy          = (tx_state_q != TX_IDLE) || !tx_fifo_empty;
    assign rx_frame_error   = rx_frame_err_q;
    assign rx_parity_error  = rx_parity_err_q;
    assign rx_overrun       = rx_overrun_q;

    always_comb begin
        tx_push     = tx_fifo_write_en && !tx_fifo_full;
        tx_wr_d     = tx_wr_q + AW'(tx_push);
        tx_rd_d     = tx_rd_q + AW'(tx_pop);
        tx_cnt_d    = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        rx_push     = rx_push_q && !rx_fifo_full;
        overrun_set = rx_push_q && rx_fifo_full;
        rx_pop      = rx_fifo_read_en && !rx_fifo_empty;
        rx_wr_d     = rx_wr_q + AW'(rx_push);
        rx_rd_d     = rx_rd_q + AW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end

    // TX: STOP chains straight into the next START so queued frames run back-to-back.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pin_d   = tx_pin_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_tick_d = '0;
                tx_load   = !tx_fifo_empty;
            end
            TX_START: if (tx_tick_q == BIT_END) begin
                tx_tick_d  = '0;
                tx_state_d = TX_DATA;
                tx_pin_d   = tx_shift_q[0];
            end
            TX_DATA: if (tx_tick_q == BIT_END) begin
                tx_tick_d  = '0;
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == LAST_BIT) begin
                    tx_bit_d = '0;
                    if (PARITY != 0) begin
                        tx_state_d = TX_PARITY;
                        tx_pin_d   = tx_par_q;
                    end else begin
                        tx_state_d = TX_STOP;
                        tx_pin_d   = 1'b1;
                    end
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_pin_d = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_tick_q == BIT_END) begin
                tx_tick_d  = '0;
                tx_state_d = TX_STOP;
                tx_pin_d   = 1'b1;
            end
            TX_STOP: if (tx_tick_q == STOP_END) begin
                tx_tick_d = '0;
                if (!tx_fifo_empty) begin
                    tx_load = 1'b1;
                end else begin
                    tx_state_d = TX_IDLE;
                    tx_pin_d   = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_state_d = TX_START;
            tx_pin_d   = 1'b0;
            tx_tick_d  = '0;
            tx_bit_d   = '0;
        end
    end

    // RX: three samples around mid-bit; the decision is taken on the third.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = (rx_tick_q == BIT_END) ? '0 : rx_tick_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_votes_d = rx_votes_q;
        rx_shift_d = rx_shift_q;
        rx_push_d  = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        rx_sum     = rx_votes_q + {1'b0, rx_sync_q};
        rx_vote    = rx_sum[1];
        if (rx_tick_q == SMP0)      rx_votes_d = {1'b0, rx_sync_q};
        else if (rx_tick_q == SMP1) rx_votes_d = rx_sum;
        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = CW'(1);
                end
            end
            RX_START: begin
                if (rx_tick_q == SMP2 && rx_vote) rx_state_d = RX_IDLE;
                else if (rx_tick_q == BIT_END) begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_tick_q == SMP2) rx_shift_d = {rx_vote, rx_shift_q[DATA_BITS-1:1]};
                if (rx_tick_q == BIT_END) begin
                    if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_tick_q == SMP2) parity_set = rx_vote != ((^rx_shift_q) ^ PAR_ODD);
                if (rx_tick_q == BIT_END) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_tick_q == SMP2) begin
                if (rx_vote) begin
                    rx_push_d  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    frame_set  = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                    rx_tick_d  = '0;
                end
            end
            RX_WAIT_HIGH: begin
                if (!rx_sync_q) rx_tick_d = '0;
                else if (rx_tick_q == BIT_END) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        rx_frame_err_d  = (rx_frame_err_q  && !error_clear) || frame_set;
        rx_parity_err_d = (rx_parity_err_q && !error_clear) || parity_set;
        rx_overrun_d    = (rx_overrun_q    && !error_clear) || overrun_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;  tx_tick_q <= '0;  tx_bit_q <= '0;  tx_pin_q <= 1'b1;
            tx_wr_q    <= '0;       tx_rd_q   <= '0;  tx_cnt_q <= '0;
            rx_meta_q  <= 1'b1;     rx_sync_q <= 1'b1; rx_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;  rx_tick_q <= '0;  rx_bit_q <= '0;  rx_push_q <= 1'b0;
            rx_wr_q    <= '0;       rx_rd_q   <= '0;  rx_cnt_q <= '0;
            rx_frame_err_q <= 1'b0; rx_parity_err_q <= 1'b0; rx_overrun_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d; tx_tick_q <= tx_tick_d; tx_bit_q <= tx_bit_d; tx_pin_q <= tx_pin_d;
            tx_wr_q    <= tx_wr_d;    tx_rd_q   <= tx_rd_d;   tx_cnt_q <= tx_cnt_d;
            rx_meta_q  <= uart_rx_pin; rx_sync_q <= rx_meta_q; rx_prev_q <= rx_sync_q;
            rx_state_q <= rx_state_d; rx_tick_q <= rx_tick_d; rx_bit_q <= rx_bit_d; rx_push_q <= rx_push_d;
            rx_wr_q    <= rx_wr_d;    rx_rd_q   <= rx_rd_d;   rx_cnt_q <= rx_cnt_d;
            rx_frame_err_q <= rx_frame_err_d; rx_parity_err_q <= rx_parity_err_d;
            rx_overrun_q   <= rx_overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        tx_par_q   <= tx_par_d;
        rx_votes_q <= rx_votes_d;
        rx_shift_q <= rx_shift_d;
        if (tx_push) tx_mem_q[tx_wr_q] <= tx_fifo_data_in;
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_shift_q;
    end

endmodule
